digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Multi-cycle, parametrised adder that splits N-bit operands into W-bit digits and adds one digit per clock, least-significant digit first.
- Trades latency for area: N/W cycles per add.
- Uses a start/busy/done handshake so a board-level top (switch operands, button-driven start, LED result) or any upstream controller can drive it.
- Successor to the single-cycle ripple-carry adder: width and digit size are generalised, and it adds sequencing, flags and optional subtraction.

Parameters:
- N, 16, operand/result width in bits. Must be a multiple of W.
- W, 4, digit width processed per cycle. 1 <= W <= N.
- K (localparam), N/W, number of digit cycles per operation.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when not busy.
- a  in  N  operand A, sampled on the accept cycle.
- b  in  N  operand B, sampled on the accept cycle.
- cin  in  1  carry-in, sampled on the accept cycle.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when a result is valid.
- sum  out  N  registered result; holds until the next completion.
- cout  out  1  carry out of bit N-1.
- ovf  out  1  two's-complement overflow flag.

Behaviour:
- Reset: synchronous on rst=1 at a clk edge.
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Digit counter and shift registers are cleared.
  - rst has priority over start, and aborts any operation in progress: no done is produced and sum is not updated.
- FSM states:
  - IDLE: busy=0. start=1 -> latch a, b, cin into operand shift registers and the carry register; set counter=0; go to RUN.
  - RUN: busy=1. Each cycle:
    - add the low W bits of A and B plus the carry register;
    - shift the W-bit digit result into the result shift register (MSB side);
    - shift A and B right by W;
    - update the carry register;
    - increment the counter.
    - When counter == K-1, load sum, cout and ovf from the final values and go to DONE.
  - DONE: done=1, busy=0, lasting exactly one cycle.
    - start=1 in DONE is accepted (back-to-back): latch new operands and go to RUN.
    - Otherwise go to IDLE.
- Latency:
  - start accepted at edge t -> done high during the cycle after edge t+K.
  - sum, cout and ovf become valid at the same edge that raises done.
- sum, cout and ovf are stable from done until the next completion; they are not modified during RUN.
- start while busy=1 is ignored; operands already latched are unaffected.
- Arithmetic is unsigned modulo 2^N.
  - cout is the final carry out of the top digit.
  - ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]), where b_eff is b, or ~b in subtract mode.
  - Latch the operand MSBs at accept for this computation.
- W == N degenerates to K=1: one RUN cycle; done two cycles after accept.
- Elaboration check: $error if N % W != 0 or W < 1 or W > N.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on accept.
  - sub=1 computes a - b: b_eff = ~b and the initial carry = 1. cin is ignored in this mode.
  - cout=1 means no borrow.
  - ovf uses b_eff as defined above.
- Undefined:
  - The sub port does not exist.
  - The block behaves as an add-only unit, exactly as described in Behaviour.

Decomposition:
- Package digit_serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} dsa_state_t;
  - a function clog2-safe counter width helper.
- One combinational sub-module, dsa_digit_adder:
  - parameter W; inputs x[W], y[W], ci; outputs s[W], co.
  - Internal full-adder ripple.
  - Instantiated once in the datapath.
- FSM, counter and shift registers live in digit_serial_adder.

Test Plan:
- N=16, W=4: a=0x00FF, b=0x0001, cin=0, start pulse -> busy for 4 cycles, done 1 cycle, sum=0x0100, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Start an op (a=0x1234, b=0x1111); reassert start with a=0xFFFF during RUN -> ignored; done gives sum=0x2345.
- Assert rst at the 2nd RUN cycle of a=0x0F0F+b=0x0101 -> next cycle busy=0, sum=0, no done pulse; a new start afterwards completes normally.
- start held high through DONE with new operands 0x0002+0x0003 -> second done exactly K+1 cycles after the first, sum=0x0005.
- With DIGIT_SERIAL_ADDER_SUB_EN, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1. Repeat the first scenario with N=8, W=8 (K=1) and N=8, W=1.

Source files
------------

// File: rtl/digit_serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_serial_adder_pkg : FSM state type and counter width helper      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_t;

    // Width of a counter spanning 0..k-1, never narrower than one bit.
    function automatic int dsa_cnt_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_serial_adder_if : start/busy/done operand and result bundle     |
// | Optional sub port under DIGIT_SERIAL_ADDER_SUB_EN.  Rev 1.0           |
// +----------------------------------------------------------------------+
interface digit_serial_adder_if #(
    parameter int N = 16
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif

endinterface
`default_nettype wire

// File: rtl/digit_serial_adder_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsa_digit_adder : combinational W-bit full-adder ripple               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsa_digit_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[W];

endmodule
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_serial_adder : N-bit add, one W-bit digit per clock, LSD first  |
// | DIGIT_SERIAL_ADDER_SUB_EN adds a - b mode.  Rev 1.0                   |
// +----------------------------------------------------------------------+
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_adder_if.slave  bus
);
    localparam int K    = N / W;
    localparam int c_cw = dsa_cnt_width(K);
    localparam logic [c_cw-1:0] c_last = c_cw'(K - 1);

    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_err
        $error("digit_serial_adder: N (%0d) must be a multiple of W (%0d), 1 <= W <= N", N, W);
    end

    dsa_state_t      r_state;
    dsa_state_t      w_state_next;
    logic [c_cw-1:0] r_cnt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_res;
    logic [N-1:0]    r_sum;
    logic            r_carry;
    logic            r_a_msb;
    logic            r_b_msb;
    logic            r_cout;
    logic            r_ovf;

    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_b_eff;
    logic            w_c0;
    logic [W-1:0]    w_digit;
    logic            w_co;
    logic [N+W-1:0]  w_res_cat;
    logic [N-1:0]    w_res_next;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the inverted operand feeds the same ripple.
    assign w_b_eff = bus.sub ? ~bus.b : bus.b;
    assign w_c0    = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_eff = bus.b;
    assign w_c0    = bus.cin;
`endif

    assign w_accept = bus.start && (r_state != RUN);
    assign w_last   = (r_cnt == c_last);

    dsa_digit_adder #(
        .W (W)
    ) u_digit (
        .x  (r_a[W-1:0]),
        .y  (r_b[W-1:0]),
        .ci (r_carry),
        .s  (w_digit),
        .co (w_co)
    );

    // New digit enters at the MSB side; after K shifts the result is aligned.
    assign w_res_cat  = {w_digit, r_res};
    assign w_res_next = w_res_cat[N+W-1:W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = bus.start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_res   <= '0;
            r_carry <= w_c0;
            r_a_msb <= bus.a[N-1];
            r_b_msb <= w_b_eff[N-1];
        end else if (r_state == RUN) begin
            r_cnt   <= r_cnt + c_cw'(1);
            r_a     <= r_a >> W;
            r_b     <= r_b >> W;
            r_res   <= w_res_next;
            r_carry <= w_co;
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_co;
                r_ovf  <= (r_a_msb == r_b_msb) && (w_digit[W-1] != r_a_msb);
            end
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_digit_serial_adder : directed + random bench with arithmetic model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_digit_serial_adder;
    localparam int N = 16;
    localparam int W = 4;
    localparam int K = N / W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    digit_serial_adder_if #(.N(N)) bus ();

    digit_serial_adder #(
        .N (N),
        .W (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Transaction-level model: result is plain (N+1)-bit arithmetic, timing is
    // "busy for K cycles after accept, then one done cycle".
    int           m_left  = 0;
    logic         m_valid = 1'b0;
    logic         m_done;
    logic [N-1:0] m_sum, p_sum;
    logic         m_cout, m_ovf, p_cout, p_ovf;
    logic [N-1:0] m_beff;
    logic         m_c0, m_sub;
    logic [N:0]   m_full;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_done  = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_sum  = p_sum;
                    m_cout = p_cout;
                    m_ovf  = p_ovf;
                end
            end else if (bus.start) begin
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
                m_sub = bus.sub;
`else
                m_sub = 1'b0;
`endif
                m_beff = m_sub ? ~bus.b : bus.b;
                m_c0   = m_sub ? 1'b1 : bus.cin;
                m_full = {1'b0, bus.a} + {1'b0, m_beff} + {{N{1'b0}}, m_c0};
                p_sum  = m_full[N-1:0];
                p_cout = m_full[N];
                p_ovf  = (bus.a[N-1] == m_beff[N-1]) && (m_full[N-1] != bus.a[N-1]);
                m_left = K;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_busy", bus.busy, m_left > 0);
            check("model_done", bus.done, m_done);
            check("model_sum",  bus.sum,  m_sum);
            check("model_cout", bus.cout, m_cout);
            check("model_ovf",  bus.ovf,  m_ovf);
        end
    end

    task automatic drive(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc, input logic ts);
        bus.a   = ta;
        bus.b   = tb_v;
        bus.cin = tc;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        bus.sub = ts;
`endif
    endtask

    task automatic wait_done(output int at, output bit found);
        found = 1'b0;
        at    = 0;
        for (int i = 0; i < K + 4 && !found; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                found = 1'b1;
                at    = edge_cnt;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles required done", K + 4);
        end
    endtask

    task automatic do_op(input string nm, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic tc, input logic ts,
                         input logic [N-1:0] es, input logic ec, input logic eo);
        int t_acc;
        int at;
        bit found;
        drive(ta, tb_v, tc, ts);
        bus.start = 1'b1;
        @(posedge clk); #2;
        t_acc     = edge_cnt;
        bus.start = 1'b0;
        wait_done(at, found);
        if (found) begin
            check({nm, "_latency"}, at - t_acc, K);
            check({nm, "_sum"},  bus.sum,  es);
            check({nm, "_cout"}, bus.cout, ec);
            check({nm, "_ovf"},  bus.ovf,  eo);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  at1, at2;
        bit  f1, f2;
        bit  seen;

        bus.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_sum",  bus.sum,  16'h0000);
        @(posedge clk); #2;

        do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("add_cin",  16'h1000, 16'h2000, 1'b1, 1'b0, 16'h3001, 1'b0, 1'b0);

        // start during RUN with new operands must be ignored
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        @(posedge clk); #2;
        drive(16'hFFFF, 16'h1111, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        wait_done(at1, f1);
        if (f1) check("ignore_sum", bus.sum, 16'h2345);
        @(posedge clk); #2;

        // reset during the second RUN cycle aborts the operation
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_sum",  bus.sum,  16'h0000);
        seen = 1'b0;
        repeat (K + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        @(posedge clk); #2;
        do_op("after_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

        // start held high through DONE: back-to-back accept
        drive(16'h0010, 16'h0020, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #2;
        drive(16'h0002, 16'h0003, 1'b0, 1'b0);
        wait_done(at1, f1);
        if (f1) check("b2b_first_sum", bus.sum, 16'h0030);
        @(posedge clk); #2 bus.start = 1'b0;
        wait_done(at2, f2);
        if (f1 && f2) begin
            check("b2b_gap", at2 - at1, K + 1);
            check("b2b_second_sum", bus.sum, 16'h0005);
        end
        @(posedge clk); #2;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        do_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_zero", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
`endif

        // random traffic, including start while busy and rare resets
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            drive(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            bus.start = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #2;
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (K + 3) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
